// File: rtl/poly_mult_host_pkg.sv
// Shared definitions for the polynomial-multiplier host controller: FSM
// encoding, register offsets, region codes and key-map base helpers.
package poly_mult_host_pkg;

  localparam int unsigned STATE_W   = 2;
  localparam int unsigned REG_COUNT = 4;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_START = 2'd1;
  localparam logic [STATE_W-1:0] ST_RUN   = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] REG_WEIGHT = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CYCLES = 2'd3;

  typedef enum logic [2:0] {
    RGN_NONE = 3'd0,
    RGN_POS  = 3'd1,
    RGN_RAND = 3'd2,
    RGN_REG  = 3'd3,
    RGN_RES  = 3'd4
  } region_e;

  typedef enum logic [2:0] {
    SRC_ZERO = 3'd0,
    SRC_POS  = 3'd1,
    SRC_RAND = 3'd2,
    SRC_RES  = 3'd3,
    SRC_REG  = 3'd4
  } rd_src_e;

  function automatic int unsigned rand_base(input int unsigned weight_max);
    return weight_max;
  endfunction

  function automatic int unsigned reg_base(input int unsigned weight_max,
                                           input int unsigned rand_depth);
    return rand_base(weight_max) + rand_depth;
  endfunction

  function automatic int unsigned res_base(input int unsigned weight_max,
                                           input int unsigned rand_depth);
    return reg_base(weight_max, rand_depth) + REG_COUNT;
  endfunction

  function automatic int unsigned key_end(input int unsigned weight_max,
                                          input int unsigned rand_depth,
                                          input int unsigned res_depth);
    return res_base(weight_max, rand_depth) + res_depth;
  endfunction

endpackage

// File: rtl/poly_mult_key_decode.sv
// Host-key decoder: splits a key into region, in-region offset and a
// mapped/unmapped flag. Bounds compare at 32 bits so no region wraps.
module poly_mult_key_decode
  import poly_mult_host_pkg::*;
#(
  parameter int unsigned KEY_W      = 12,
  parameter int unsigned WEIGHT_MAX = 75,
  parameter int unsigned RAND_DEPTH = 1106,
  parameter int unsigned RES_DEPTH  = 1106
) (
  input  logic [KEY_W-1:0] key_i,
  output region_e          region_c,
  output logic [KEY_W-1:0] offset_c,
  output logic             legal_c
);

  localparam int unsigned RAND_B = rand_base(WEIGHT_MAX);
  localparam int unsigned REG_B  = reg_base(WEIGHT_MAX, RAND_DEPTH);
  localparam int unsigned RES_B  = res_base(WEIGHT_MAX, RAND_DEPTH);
  localparam int unsigned END_B  = key_end(WEIGHT_MAX, RAND_DEPTH, RES_DEPTH);

  logic [31:0] key_ext;

  // Region select and offset by key-width subtraction from the region base
  always_comb begin
    key_ext  = 32'(key_i);
    region_c = RGN_NONE;
    offset_c = '0;
    legal_c  = 1'b0;
    if (key_ext < RAND_B) begin
      region_c = RGN_POS;
      offset_c = key_i;
      legal_c  = 1'b1;
    end else if (key_ext < REG_B) begin
      region_c = RGN_RAND;
      offset_c = key_i - KEY_W'(RAND_B);
      legal_c  = 1'b1;
    end else if (key_ext < RES_B) begin
      region_c = RGN_REG;
      offset_c = key_i - KEY_W'(REG_B);
      legal_c  = 1'b1;
    end else if (key_ext < END_B) begin
      region_c = RGN_RES;
      offset_c = key_i - KEY_W'(RES_B);
      legal_c  = 1'b1;
    end
  end

endmodule

// File: rtl/poly_mult_host_ctrl.sv
// Host-side controller for the sparse polynomial multiplier: maps host keys
// onto the position/random RAMs, control registers and result port, and
// sequences one core run per start command.
module poly_mult_host_ctrl
  import poly_mult_host_pkg::*;
#(
  parameter int unsigned WEIGHT_MAX = 75,
  parameter int unsigned POS_W      = 16,
  parameter int unsigned RAND_DEPTH = 1106,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned RES_DEPTH  = 1106,
  parameter int unsigned KEY_W      = 12,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned TIMEOUT    = 2**24
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load_i,
  input  logic                            we_i,
  input  logic [KEY_W-1:0]                key_i,
  input  logic [DATA_W-1:0]               data_i,
  output logic [DATA_W-1:0]               data_o,
  output logic                            rvalid_o,
  output logic                            busy_o,
  output logic                            err_o,
  output logic                            pos_we_o,
  output logic [$clog2(WEIGHT_MAX)-1:0]   pos_addr_o,
  output logic [POS_W-1:0]                pos_din_o,
  input  logic [POS_W-1:0]                pos_dout_i,
  output logic                            rand_we_o,
  output logic [$clog2(RAND_DEPTH)-1:0]   rand_addr_o,
  output logic [WORD_W-1:0]               rand_din_o,
  input  logic [WORD_W-1:0]               rand_dout_i,
  output logic                            core_start_o,
  output logic [$clog2(WEIGHT_MAX+1)-1:0] core_weight_o,
  input  logic                            core_valid_i,
  output logic                            core_rd_o,
  output logic [$clog2(RES_DEPTH)-1:0]    core_res_addr_o,
  input  logic [WORD_W-1:0]               core_dout_i
);

  localparam int unsigned POS_AW  = $clog2(WEIGHT_MAX);
  localparam int unsigned RAND_AW = $clog2(RAND_DEPTH);
  localparam int unsigned WGT_W   = $clog2(WEIGHT_MAX + 1);
  localparam int unsigned RES_AW  = $clog2(RES_DEPTH);
  localparam int unsigned CYC_W   = WORD_W;

  region_e             region_c;
  logic [KEY_W-1:0]    offset_c;
  logic                legal_c;

  logic [STATE_W-1:0]  state_q, state_nx;
  logic                err_nx;
  logic [WORD_W-1:0]   weight_q, weight_nx;
  logic                weight_ovf_q, weight_ovf_nx;
  logic [CYC_W-1:0]    cycles_q, cycles_nx, cycles_inc;
  logic                rd_q, rd_nx;
  rd_src_e             rd_src_q, rd_src_nx;
  logic [WORD_W-1:0]   reg_val_q, reg_val_nx;

  logic acc_wr, acc_rd, wr_ok, weight_ok, timeout_hit;
  logic is_weight, is_ctrl, is_status, is_cycles;

  poly_mult_key_decode #(
    .KEY_W      (KEY_W),
    .WEIGHT_MAX (WEIGHT_MAX),
    .RAND_DEPTH (RAND_DEPTH),
    .RES_DEPTH  (RES_DEPTH)
  ) u_key_decode (
    .key_i    (key_i),
    .region_c (region_c),
    .offset_c (offset_c),
    .legal_c  (legal_c)
  );

  assign core_weight_o = weight_q[WGT_W-1:0];

  // Next-state, host access decode and combinational RAM/result port drive
  always_comb begin
    state_nx        = state_q;
    err_nx          = err_o;
    weight_nx       = weight_q;
    weight_ovf_nx   = weight_ovf_q;
    cycles_nx       = cycles_q;
    rd_nx           = 1'b0;
    rd_src_nx       = SRC_ZERO;
    reg_val_nx      = '0;
    pos_we_o        = 1'b0;
    pos_addr_o      = POS_AW'(offset_c);
    pos_din_o       = data_i[POS_W-1:0];
    rand_we_o       = 1'b0;
    rand_addr_o     = RAND_AW'(offset_c);
    rand_din_o      = data_i[WORD_W-1:0];
    core_rd_o       = 1'b0;
    core_res_addr_o = RES_AW'(offset_c);

    acc_wr    = load_i & we_i;
    acc_rd    = load_i & ~we_i;
    wr_ok     = (state_q == ST_IDLE) || (state_q == ST_DONE);
    is_weight = (region_c == RGN_REG) && (offset_c == KEY_W'(REG_WEIGHT));
    is_ctrl   = (region_c == RGN_REG) && (offset_c == KEY_W'(REG_CTRL));
    is_status = (region_c == RGN_REG) && (offset_c == KEY_W'(REG_STATUS));
    is_cycles = (region_c == RGN_REG) && (offset_c == KEY_W'(REG_CYCLES));
    weight_ok = !weight_ovf_q && (weight_q != '0) &&
                (weight_q <= WORD_W'(WEIGHT_MAX));
    cycles_inc  = (cycles_q == '1) ? cycles_q : cycles_q + CYC_W'(1);
    timeout_hit = (cycles_inc >= CYC_W'(TIMEOUT));

    if (acc_wr) begin
      if (!wr_ok || !legal_c) begin
        err_nx = 1'b1;
      end else begin
        case (region_c)
          RGN_POS:  pos_we_o  = 1'b1;
          RGN_RAND: rand_we_o = 1'b1;
          RGN_REG: begin
            if (is_weight) begin
              weight_nx     = data_i[WORD_W-1:0];
              weight_ovf_nx = ((data_i >> WORD_W) != '0);
            end else if (is_ctrl) begin
              // Error clear is applied before the start is qualified
              if (data_i[1]) err_nx = 1'b0;
              if (data_i[0]) begin
                if (weight_ok) state_nx = ST_START;
                else           err_nx   = 1'b1;
              end
            end else begin
              err_nx = 1'b1;
            end
          end
          default: err_nx = 1'b1;
        endcase
      end
    end

    if (acc_rd) begin
      rd_nx = 1'b1;
      case (region_c)
        RGN_POS:  rd_src_nx = SRC_POS;
        RGN_RAND: rd_src_nx = SRC_RAND;
        RGN_RES: begin
          if (state_q == ST_DONE) begin
            core_rd_o = 1'b1;
            rd_src_nx = SRC_RES;
          end else begin
            err_nx = 1'b1;
          end
        end
        RGN_REG: begin
          rd_src_nx = SRC_REG;
          if (is_weight)      reg_val_nx = weight_q;
          else if (is_status) reg_val_nx = WORD_W'({err_o, state_q, busy_o});
          else if (is_cycles) reg_val_nx = cycles_q;
        end
        default: err_nx = 1'b1;
      endcase
    end

    case (state_q)
      ST_START: begin
        state_nx  = ST_RUN;
        cycles_nx = '0;
      end
      ST_RUN: begin
        cycles_nx = cycles_inc;
        if (core_valid_i) begin
          state_nx = ST_DONE;
        end else if (timeout_hit) begin
          state_nx = ST_DONE;
          err_nx   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State, control registers and two-stage read pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      err_o        <= 1'b0;
      busy_o       <= 1'b0;
      core_start_o <= 1'b0;
      weight_q     <= '0;
      weight_ovf_q <= 1'b0;
      cycles_q     <= '0;
      rd_q         <= 1'b0;
      rd_src_q     <= SRC_ZERO;
      reg_val_q    <= '0;
      rvalid_o     <= 1'b0;
      data_o       <= '0;
    end else begin
      state_q      <= state_nx;
      err_o        <= err_nx;
      busy_o       <= (state_nx == ST_RUN);
      core_start_o <= (state_nx == ST_START);
      weight_q     <= weight_nx;
      weight_ovf_q <= weight_ovf_nx;
      cycles_q     <= cycles_nx;
      rd_q         <= rd_nx;
      rd_src_q     <= rd_src_nx;
      reg_val_q    <= reg_val_nx;
      rvalid_o     <= rd_q;
      if (rd_q) begin
        case (rd_src_q)
          SRC_POS:  data_o <= DATA_W'(pos_dout_i);
          SRC_RAND: data_o <= DATA_W'(rand_dout_i);
          SRC_RES:  data_o <= DATA_W'(core_dout_i);
          SRC_REG:  data_o <= DATA_W'(reg_val_q);
          default:  data_o <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_poly_mult_host_ctrl.sv
// Directed self-checking bench for poly_mult_host_ctrl. A second instance
// with a short run limit covers the timeout path.
module tb_poly_mult_host_ctrl;

  localparam logic [11:0] K_POS3   = 12'd3;
  localparam logic [11:0] K_POS4   = 12'd4;
  localparam logic [11:0] K_RAND5  = 12'd80;
  localparam logic [11:0] K_RAND6  = 12'd81;
  localparam logic [11:0] K_WEIGHT = 12'd1181;
  localparam logic [11:0] K_CTRL   = 12'd1182;
  localparam logic [11:0] K_STATUS = 12'd1183;
  localparam logic [11:0] K_CYCLES = 12'd1184;
  localparam logic [11:0] K_RES0   = 12'd1185;
  localparam logic [11:0] K_RES7   = 12'd1192;
  localparam logic [11:0] K_END    = 12'd2291;
  localparam logic [11:0] K_TOP    = 12'hFFF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load, we;
  logic [11:0]  key;
  logic [127:0] wdata;
  logic         core_valid;

  logic [127:0] rdata;
  logic         rvalid, busy, err;
  logic         pos_we, rand_we, core_start, core_rd;
  logic [6:0]   pos_addr, core_weight;
  logic [15:0]  pos_din, pos_dout;
  logic [10:0]  rand_addr, core_res_addr;
  logic [31:0]  rand_din, rand_dout, core_dout;

  logic [127:0] t_rdata;
  logic         t_rvalid, t_busy, t_err;
  logic         t_pos_we, t_rand_we, t_core_start, t_core_rd;
  logic [6:0]   t_pos_addr, t_core_weight;
  logic [15:0]  t_pos_din;
  logic [10:0]  t_rand_addr, t_core_res_addr;
  logic [31:0]  t_rand_din;
  logic         t_valid = 1'b0;
  logic [15:0]  zero_pos = '0;
  logic [31:0]  zero_word = '0;

  logic [15:0]  pos_mem  [0:127];
  logic [31:0]  rand_mem [0:2047];

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  logic wr_pos_we, wr_rand_we;

  always #5 clk = ~clk;

  poly_mult_host_ctrl dut (
    .clk(clk), .rst_n(rst_n), .load_i(load), .we_i(we), .key_i(key),
    .data_i(wdata), .data_o(rdata), .rvalid_o(rvalid), .busy_o(busy),
    .err_o(err), .pos_we_o(pos_we), .pos_addr_o(pos_addr),
    .pos_din_o(pos_din), .pos_dout_i(pos_dout), .rand_we_o(rand_we),
    .rand_addr_o(rand_addr), .rand_din_o(rand_din), .rand_dout_i(rand_dout),
    .core_start_o(core_start), .core_weight_o(core_weight),
    .core_valid_i(core_valid), .core_rd_o(core_rd),
    .core_res_addr_o(core_res_addr), .core_dout_i(core_dout)
  );

  poly_mult_host_ctrl #(.TIMEOUT(16)) dut_to (
    .clk(clk), .rst_n(rst_n), .load_i(load), .we_i(we), .key_i(key),
    .data_i(wdata), .data_o(t_rdata), .rvalid_o(t_rvalid), .busy_o(t_busy),
    .err_o(t_err), .pos_we_o(t_pos_we), .pos_addr_o(t_pos_addr),
    .pos_din_o(t_pos_din), .pos_dout_i(zero_pos), .rand_we_o(t_rand_we),
    .rand_addr_o(t_rand_addr), .rand_din_o(t_rand_din),
    .rand_dout_i(zero_word), .core_start_o(t_core_start),
    .core_weight_o(t_core_weight), .core_valid_i(t_valid),
    .core_rd_o(t_core_rd), .core_res_addr_o(t_core_res_addr),
    .core_dout_i(zero_word)
  );

  // Synchronous RAMs and result store with one-cycle read latency
  always @(posedge clk) begin
    if (pos_we) pos_mem[pos_addr] <= pos_din;
    if (rand_we) rand_mem[rand_addr] <= rand_din;
    pos_dout  <= pos_mem[pos_addr];
    rand_dout <= rand_mem[rand_addr];
    core_dout <= 32'hA5A5_0000 | 32'(core_res_addr);
  end

  always @(negedge clk) if (core_start) start_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [11:0] k, input logic [127:0] d);
    @(posedge clk); #1;
    load = 1'b1; we = 1'b1; key = k; wdata = d;
    #1;
    wr_pos_we  = pos_we;
    wr_rand_we = rand_we;
    @(posedge clk); #1;
    load = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [11:0] k, output logic [127:0] d,
                        output logic v1, output logic v2);
    @(posedge clk); #1;
    load = 1'b1; we = 1'b0; key = k;
    @(posedge clk); #1;
    load = 1'b0;
    v1 = rvalid;
    @(posedge clk); #1;
    v2 = rvalid;
    d  = rdata;
  endtask

  initial begin
    logic [127:0] d;
    logic v1, v2;
    int s0;
    load = 1'b0; we = 1'b0; key = '0; wdata = '0; core_valid = 1'b0;
    wr_pos_we = 1'b0; wr_rand_we = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_data",   rdata,                128'(0));
    chk("rst_rvalid", 128'(rvalid),         128'(0));
    chk("rst_busy",   128'(busy),           128'(0));
    chk("rst_err",    128'(err),            128'(0));
    chk("rst_start",  128'(core_start),     128'(0));
    chk("rst_weight", 128'(core_weight),    128'(0));
    chk("rst_t_busy", 128'(t_busy),         128'(0));
    rst_n = 1'b1;

    bus_wr(K_POS3, 128'h1A2B);
    chk("pos_we", 128'(wr_pos_we), 128'(1));
    bus_rd(K_POS3, d, v1, v2);
    chk("pos_rv_edge1", 128'(v1), 128'(0));
    chk("pos_rv_edge2", 128'(v2), 128'(1));
    chk("pos_rdata",    d,        128'h1A2B);
    bus_wr(K_POS4, {112'h1234_5678_9ABC_DEF0_1122_3344_5566, 16'hBEEF});

    // Back-to-back reads
    @(posedge clk); #1; load = 1'b1; we = 1'b0; key = K_POS3;
    @(posedge clk); #1; key = K_POS4;
    chk("b2b_rv0", 128'(rvalid), 128'(0));
    @(posedge clk); #1; load = 1'b0;
    chk("b2b_rv1", 128'(rvalid), 128'(1));
    chk("b2b_d1",  rdata,        128'h1A2B);
    @(posedge clk); #1;
    chk("b2b_rv2", 128'(rvalid), 128'(1));
    chk("b2b_d2",  rdata,        128'hBEEF);
    @(posedge clk); #1;
    chk("b2b_rv3", 128'(rvalid), 128'(0));

    bus_wr(K_RAND5, 128'hCAFE_F00D);
    chk("rand_we", 128'(wr_rand_we), 128'(1));
    bus_rd(K_RAND5, d, v1, v2);
    chk("rand_rdata", d, 128'hCAFE_F00D);

    // Unmapped accesses
    bus_rd(K_END, d, v1, v2);
    chk("unmap_rv",  128'(v2),  128'(1));
    chk("unmap_d",   d,         128'(0));
    chk("unmap_err", 128'(err), 128'(1));
    bus_rd(K_STATUS, d, v1, v2);
    chk("status_err_idle", d, 128'h8);
    bus_wr(K_CTRL, 128'h2);
    chk("err_clear", 128'(err), 128'(0));
    bus_wr(K_TOP, 128'h5);
    chk("unmap_wr_err", 128'(err), 128'(1));
    bus_wr(K_CTRL, 128'h2);

    // Start refused on zero and over-range weight
    s0 = start_cnt;
    bus_wr(K_CTRL, 128'h1);
    chk("w0_start", 128'(core_start), 128'(0));
    chk("w0_err",   128'(err),        128'(1));
    @(posedge clk); #1;
    chk("w0_busy",  128'(busy),             128'(0));
    chk("w0_cnt",   128'(start_cnt - s0),   128'(0));
    bus_wr(K_CTRL, 128'h2);
    chk("w0_clear", 128'(err), 128'(0));
    bus_wr(K_WEIGHT, 128'd76);
    bus_wr(K_CTRL, 128'h3);
    chk("w76_err",   128'(err),        128'(1));
    chk("w76_start", 128'(core_start), 128'(0));
    bus_wr(K_CTRL, 128'h2);

    // Normal run finished by the core after 500 cycles
    bus_wr(K_WEIGHT, 128'd66);
    chk("core_weight", 128'(core_weight), 128'd66);
    bus_rd(K_WEIGHT, d, v1, v2);
    chk("weight_rd", d, 128'd66);
    s0 = start_cnt;
    bus_wr(K_CTRL, 128'h1);
    chk("run_start_hi", 128'(core_start), 128'(1));
    chk("run_busy_st",  128'(busy),       128'(0));
    @(posedge clk); #1;
    chk("run_start_lo", 128'(core_start), 128'(0));
    chk("run_busy",     128'(busy),       128'(1));
    repeat (499) @(posedge clk);
    #1;
    chk("run_busy_499", 128'(busy), 128'(1));
    core_valid = 1'b1;
    @(posedge clk); #1;
    core_valid = 1'b0;
    chk("done_busy",  128'(busy),           128'(0));
    chk("done_err",   128'(err),            128'(0));
    chk("start_once", 128'(start_cnt - s0), 128'(1));
    bus_rd(K_STATUS, d, v1, v2);
    chk("status_done", d, 128'h6);
    bus_rd(K_CYCLES, d, v1, v2);
    chk("cycles_500", d, 128'd500);
    bus_rd(K_RES7, d, v1, v2);
    chk("res_rv", 128'(v2), 128'(1));
    chk("res_d",  d,        128'hA5A5_0007);
    bus_wr(K_CYCLES, 128'h0);
    chk("cyc_wr_err", 128'(err), 128'(1));
    bus_rd(K_CYCLES, d, v1, v2);
    chk("cyc_kept", d, 128'd500);
    bus_wr(K_CTRL, 128'h2);

    // Result read outside DONE, then timeout on the short-limit instance
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    bus_rd(K_RES0, d, v1, v2);
    chk("res_idle_rv",  128'(v2),    128'(1));
    chk("res_idle_d",   d,           128'(0));
    chk("res_idle_err", 128'(err),   128'(1));
    bus_wr(K_CTRL, 128'h2);
    chk("t_clear", 128'(t_err), 128'(0));
    bus_wr(K_WEIGHT, 128'd10);
    bus_wr(K_CTRL, 128'h1);
    chk("t_start", 128'(t_core_start), 128'(1));
    @(posedge clk); #1;
    chk("t_busy_run", 128'(t_busy), 128'(1));
    repeat (15) @(posedge clk);
    #1;
    chk("t_busy_15", 128'(t_busy), 128'(1));
    chk("t_err_15",  128'(t_err),  128'(0));
    @(posedge clk); #1;
    chk("t_busy_16", 128'(t_busy), 128'(0));
    chk("t_err_16",  128'(t_err),  128'(1));
    bus_rd(K_STATUS, d, v1, v2);
    chk("t_status",    t_rdata, 128'hE);
    chk("main_status", d,       128'h5);

    // Write into the random region while running is rejected
    bus_wr(K_RAND6, 128'h1111);
    chk("run_rand_we", 128'(wr_rand_we), 128'(0));
    chk("run_wr_err",  128'(err),        128'(1));
    bus_rd(K_RAND5, d, v1, v2);
    chk("run_rand_rd", d, 128'hCAFE_F00D);

    // Asynchronous reset mid-run
    s0 = start_cnt;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",   128'(busy),       128'(0));
    chk("arst_err",    128'(err),        128'(0));
    chk("arst_rvalid", 128'(rvalid),     128'(0));
    chk("arst_data",   rdata,            128'(0));
    chk("arst_start",  128'(core_start), 128'(0));
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_busy",  128'(busy),           128'(0));
    chk("post_start", 128'(start_cnt - s0), 128'(0));
    bus_rd(K_STATUS, d, v1, v2);
    chk("post_status", d, 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
